pc_gen: RTL and testbench

PC_GEN -- requirements
Module: pc_gen

---
 rtl/pc_pkg.sv | 20 ++
 rtl/pc_ras.sv | 66 ++++++
 rtl/pc_gen.sv | 101 ++++++++++
 tb/tb_pc_gen.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared definitions for the fetch PC generator.
// Step sizes, next-PC select encoding and RAS sizing helper.
package pc_pkg;

  localparam int STEP_C = 2;
  localparam int STEP_I = 4;

  typedef enum logic [2:0] {
    SEL_HOLD,
    SEL_TRAP,
    SEL_REDIR,
    SEL_RAS,
    SEL_SEQ
  } pc_sel_e;

  function automatic int ras_cw(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/pc_ras.sv
// Return-address stack: circular buffer with a top pointer
// and a saturating live-entry count; data storage is not reset.
module pc_ras
  import pc_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = ras_cw(DEPTH)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            push_i,
  input  logic [XLEN-1:0] link_i,
  input  logic            pop_i,
  input  logic            flush_i,
  output logic [XLEN-1:0] top_o,
  output logic [CW-1:0]   count_o
);

  logic [PW-1:0]   top_q, top_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] mem_q [DEPTH];
  logic            wr_en;
  logic [PW-1:0]   wr_ptr;

  always_comb begin
    top_d  = top_q;
    cnt_d  = cnt_q;
    wr_en  = 1'b0;
    wr_ptr = top_q + 1'b1;
    if (flush_i) begin
      cnt_d = '0;
    end else if (push_i) begin
      // A full stack wraps onto the oldest slot.
      wr_en = 1'b1;
      top_d = wr_ptr;
      if (cnt_q != CW'(DEPTH)) begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (pop_i && cnt_q != '0) begin
      top_d = top_q - 1'b1;
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      top_q <= '0;
      cnt_q <= '0;
    end else begin
      top_q <= top_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en && reset) begin
      mem_q[wr_ptr] <= link_i;
    end
  end

  assign top_o   = mem_q[top_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator: trap, redirect, RAS-predicted return,
// sequential step, or hold, in that priority order.
module pc_gen
  import pc_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter int              RAS_DEPTH = 4,
  parameter int              C_EXT     = 1,
  localparam int             CW        = ras_cw(RAS_DEPTH)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            io_trap,
  input  logic [XLEN-1:0] io_trap_vec,
  input  logic            io_redirect,
  input  logic [XLEN-1:0] io_npc,
  input  logic            io_call,
  input  logic [XLEN-1:0] io_link,
  input  logic            io_ret,
  input  logic            io_is_c,
  input  logic            io_ready,
  output logic            io_valid,
  output logic [XLEN-1:0] io_pc,
  output logic [CW-1:0]   io_ras_count
);

  localparam logic [XLEN-1:0] AMASK =
    (C_EXT != 0) ? ~XLEN'(1) : ~XLEN'(3);
  localparam logic [XLEN-1:0] RST_PC = RESET_VEC & AMASK;

  logic [XLEN-1:0] pc_q, pc_d;
  logic            valid_q, valid_d;
  logic [XLEN-1:0] step;
  logic [XLEN-1:0] ras_top;
  logic [CW-1:0]   ras_cnt;
  logic            fire;
  logic            push;
  logic            pop;
  pc_sel_e         sel;

  always_comb begin
    fire = valid_q && io_ready;
    step = (C_EXT != 0 && io_is_c) ? XLEN'(STEP_C)
                                   : XLEN'(STEP_I);
    sel  = SEL_HOLD;
    if (io_trap) begin
      sel = SEL_TRAP;
    end else if (io_redirect) begin
      sel = SEL_REDIR;
    end else if (fire && io_ret && ras_cnt != '0) begin
      sel = SEL_RAS;
    end else if (fire) begin
      sel = SEL_SEQ;
    end
  end

  always_comb begin
    pc_d    = pc_q;
    valid_d = 1'b1;
    unique case (sel)
      SEL_TRAP:  pc_d = io_trap_vec & AMASK;
      SEL_REDIR: pc_d = io_npc & AMASK;
      SEL_RAS:   pc_d = ras_top & AMASK;
      SEL_SEQ:   pc_d = (pc_q + step) & AMASK;
      default:   pc_d = pc_q;
    endcase
  end

  assign push = io_redirect && io_call && !io_trap;
  assign pop  = (sel == SEL_RAS);

  pc_ras #(
    .XLEN  (XLEN),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clock   (clock),
    .reset   (reset),
    .push_i  (push),
    .link_i  (io_link),
    .pop_i   (pop),
    .flush_i (io_trap),
    .top_o   (ras_top),
    .count_o (ras_cnt)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_q    <= RST_PC;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      valid_q <= valid_d;
    end
  end

  assign io_pc        = pc_q;
  assign io_valid     = valid_q;
  assign io_ras_count = ras_cnt;

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: directed cases plus random traffic
// checked against a queue-based reference model.
module tb_pc_gen;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic        trap, redirect, call, ret, is_c, ready;
  logic [31:0] tvec, npc, link;
  logic        valid;
  logic [31:0] pc;
  logic [2:0]  cnt;

  logic        b_trap, b_redirect, b_call, b_ret, b_is_c, b_ready;
  logic [31:0] b_tvec, b_npc, b_link;
  logic        b_valid;
  logic [31:0] b_pc;
  logic [2:0]  b_cnt;

  pc_gen #(
    .XLEN(32), .RESET_VEC(32'h0), .RAS_DEPTH(4), .C_EXT(1)
  ) u_dut (
    .clock(clock), .reset(reset),
    .io_trap(trap), .io_trap_vec(tvec),
    .io_redirect(redirect), .io_npc(npc),
    .io_call(call), .io_link(link),
    .io_ret(ret), .io_is_c(is_c), .io_ready(ready),
    .io_valid(valid), .io_pc(pc), .io_ras_count(cnt)
  );

  pc_gen #(
    .XLEN(32), .RESET_VEC(32'h0), .RAS_DEPTH(4), .C_EXT(0)
  ) u_dut_noc (
    .clock(clock), .reset(reset),
    .io_trap(b_trap), .io_trap_vec(b_tvec),
    .io_redirect(b_redirect), .io_npc(b_npc),
    .io_call(b_call), .io_link(b_link),
    .io_ret(b_ret), .io_is_c(b_is_c), .io_ready(b_ready),
    .io_valid(b_valid), .io_pc(b_pc), .io_ras_count(b_cnt)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               tag, got, exp);
    end
  endtask

  logic [31:0] m_pc;
  bit          m_valid;
  logic [31:0] m_ras[$];

  task automatic model_reset();
    m_pc    = 32'h0;
    m_valid = 1'b0;
    m_ras.delete();
  endtask

  task automatic model_step();
    bit          fire;
    logic [31:0] st;
    fire = m_valid && ready;
    st   = is_c ? 32'd2 : 32'd4;
    if (trap) begin
      m_pc = tvec & ~32'h1;
      m_ras.delete();
    end else if (redirect) begin
      m_pc = npc & ~32'h1;
      if (call) begin
        m_ras.push_back(link);
        if (m_ras.size() > 4) void'(m_ras.pop_front());
      end
    end else if (fire && ret && m_ras.size() > 0) begin
      m_pc = m_ras.pop_back() & ~32'h1;
    end else if (fire) begin
      m_pc = m_pc + st;
    end
    m_valid = 1'b1;
  endtask

  task automatic cyc(input logic t, input logic [31:0] tv,
                     input logic rd, input logic [31:0] np,
                     input logic cl, input logic [31:0] lk,
                     input logic rt, input logic c,
                     input logic rdy);
    trap = t; tvec = tv; redirect = rd; npc = np;
    call = cl; link = lk; ret = rt; is_c = c; ready = rdy;
    model_step();
    @(posedge clock);
    @(negedge clock);
    chk("pc", pc, m_pc);
    chk("valid", valid, m_valid);
    chk("count", cnt, m_ras.size());
  endtask

  task automatic idle(input logic rdy, input logic c);
    cyc(0, 0, 0, 0, 0, 0, 0, c, rdy);
  endtask

  initial begin
    trap = 0; tvec = 0; redirect = 0; npc = 0;
    call = 0; link = 0; ret = 0; is_c = 0; ready = 1;
    b_trap = 0; b_tvec = 0; b_redirect = 0; b_npc = 0;
    b_call = 0; b_link = 0; b_ret = 0; b_is_c = 0;
    b_ready = 0;
    model_reset();

    repeat (2) @(negedge clock);
    chk("rst_valid", valid, 0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_count", cnt, 0);
    reset = 1'b1;

    idle(1, 0);
    chk("seq0", pc, 32'h0);
    chk("valid_up", valid, 1);
    idle(1, 0);
    chk("seq4", pc, 32'h4);
    idle(1, 0);
    chk("seq8", pc, 32'h8);

    idle(0, 1);
    idle(0, 1);
    chk("stall_hold", pc, 32'h8);
    idle(1, 1);
    chk("c_step", pc, 32'hA);

    cyc(1, 32'h100, 1, 32'h200, 1, 32'h99, 0, 0, 1);
    chk("trap_prio", pc, 32'h100);
    chk("trap_flush", cnt, 0);

    cyc(0, 0, 1, 32'h400, 1, 32'h14, 0, 0, 0);
    chk("call_pc", pc, 32'h400);
    chk("call_cnt", cnt, 1);
    cyc(0, 0, 0, 0, 0, 0, 1, 0, 1);
    chk("ret_pc", pc, 32'h14);
    chk("ret_cnt", cnt, 0);

    for (int k = 1; k <= 5; k++)
      cyc(0, 0, 1, 32'h1000, 1, 32'(k * 16), 0, 0, 1);
    chk("ras_sat", cnt, 4);
    for (int k = 0; k < 4; k++) begin
      cyc(0, 0, 0, 0, 0, 0, 1, 0, 1);
      chk("ras_pop", pc, 32'(32'h50 - k * 16));
    end
    cyc(0, 0, 0, 0, 0, 0, 1, 0, 1);
    chk("ras_empty_seq", pc, 32'h24);
    chk("ras_empty_cnt", cnt, 0);

    cyc(0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0, 1);
    idle(1, 0);
    chk("wrap", pc, 32'h0);

    b_redirect = 1; b_npc = 32'h202;
    idle(0, 0);
    chk("noc_align", b_pc, 32'h200);
    b_redirect = 0; b_ready = 1; b_is_c = 1;
    idle(0, 0);
    chk("noc_step", b_pc, 32'h204);
    b_ready = 0;

    cyc(0, 0, 1, 32'h800, 1, 32'h30, 0, 0, 1);
    trap = 0; redirect = 1; npc = 32'h300;
    call = 1; link = 32'h77; ready = 1;
    #2 reset = 1'b0;
    @(posedge clock);
    #1;
    chk("mid_rst_pc", pc, 32'h0);
    chk("mid_rst_valid", valid, 0);
    chk("mid_rst_cnt", cnt, 0);
    @(negedge clock);
    redirect = 0; call = 0;
    model_reset();
    reset = 1'b1;
    idle(1, 0);
    chk("post_rst_pc", pc, 32'h0);

    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(15) == 0, $urandom,
          $urandom_range(5) == 0, $urandom,
          $urandom_range(1) == 1, $urandom,
          $urandom_range(2) == 0, $urandom_range(1) == 1,
          $urandom_range(3) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
